ad9467_adc_capture: RTL
=======================

AD9467_ADC_CAPTURE -- requirements
Module: ad9467_adc_capture

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning FIFO address width (depth = 2^FIFO_AW 32-bit words, legal 2..10).
REQ-002 SHALL have port adc_clk  in  1  sample clock; the only clock.
REQ-003 SHALL have port adc_rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port adc_valid  in  1  sample qualifier from the ADC core.
REQ-005 SHALL have port adc_enable  in  1  channel enable from the ADC core.
REQ-006 SHALL have port adc_data  in  16  formatted sample.
REQ-007 SHALL have port adc_dovf  out  1  sticky overflow, fed back to the ADC core status.
REQ-008 SHALL have port ovf_clear  in  1  one-cycle pulse that clears adc_dovf.
REQ-009 SHALL have port capture_start  in  1  one-cycle pulse that starts a capture.
REQ-010 SHALL have port capture_len  in  16  number of 32-bit words to capture, sampled on capture_start.
REQ-011 SHALL have port capture_busy  out  1  high whenever state is not IDLE.
REQ-012 SHALL have port capture_done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port m_valid  out  1  output word valid.
REQ-014 SHALL have port m_ready  in  1  output word accepted.
REQ-015 SHALL have port m_data  out  32  output word; the older sample is in [15:0] and the newer sample in [31:16].
REQ-016 SHALL have port m_last  out  1  marks the final word of a completed capture.

Function
REQ-017 SHALL implement the states IDLE, CAPTURE and DRAIN.
REQ-018 SHALL, when capture_start=1 in IDLE and capture_len!=0, load the word counter with capture_len, clear the pack phase and enter CAPTURE on the next edge.
REQ-019 SHALL ignore capture_start when capture_len=0 or when the state is not IDLE.
REQ-020 SHALL, in CAPTURE, accept a sample only on an edge where adc_valid=1 and adc_enable=1; other samples are discarded and the pack phase is held.
REQ-021 SHALL, at phase 0, register the accepted sample as the low half and set the phase to 1.
REQ-022 SHALL, at phase 1, write {adc_data, low half} into the FIFO on the same edge, clear the phase and decrement the word counter.
REQ-023 SHALL store m_last=1 with the word that decrements the word counter from 1 to 0, and then enter DRAIN.
REQ-024 SHALL assert m_valid in the cycle after the edge that writes a word into an empty FIFO (1-cycle latency); the FIFO is first-word-fall-through.
REQ-025 SHALL pop a word on an edge where m_valid=1 and m_ready=1, and SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-026 SHALL treat a write to a full FIFO as accepted when a pop occurs on the same edge.
REQ-027 SHALL treat a write to a full FIFO with no pop as an overflow: the word is dropped, adc_dovf is set, the pending phase is cleared and the state goes to DRAIN (abort); no m_last is produced for that capture.
REQ-028 SHALL clear adc_dovf on ovf_clear; when ovf_clear and a new overflow occur on the same edge, set wins.
REQ-029 SHALL, in DRAIN, move to IDLE on the edge where the FIFO becomes or is empty, and SHALL assert capture_done for exactly one cycle after that edge.
REQ-030 SHALL use wrap-around FIFO pointers of FIFO_AW+1 bits, with full = MSBs differ and low bits equal, and empty = pointers equal.
REQ-031 SHALL use a 16-bit word counter that never underflows.

Reset
REQ-032 SHALL, while adc_rst=1 (asynchronous assertion), hold state=IDLE, FIFO empty, pack phase 0 and word counter 0.
REQ-033 SHALL, while adc_rst=1, drive adc_dovf, capture_busy, capture_done, m_valid and m_last to 0 and m_data to 0.
REQ-034 SHALL, when reset asserts mid-capture, discard all buffered words with no m_last and no capture_done; after release, the block is idle and accepts a new capture_start.

Verification
REQ-035 Basic: capture_len=3, samples 1..6 continuous, m_ready=1 -> words 0x00020001, 0x00040003, 0x00060005; m_last only on the third; capture_done one cycle after it pops.
REQ-036 Gaps: capture_len=1, samples 0xAAAA, (adc_enable=0, 0x1111), 0xBBBB -> a single word 0xBBBBAAAA with m_last=1; 0x1111 absent.
REQ-037 Overflow: FIFO_AW=2, capture_len=10, m_ready=0 -> 4 words buffered, fifth completed word sets adc_dovf, capture_busy stays 1; raising m_ready drains 4 words with m_last=0, then capture_done; ovf_clear -> adc_dovf=0.
REQ-038 Full boundary: FIFO full, with m_ready=1 on the edge a word completes -> no overflow, adc_dovf stays 0, count stays 4.
REQ-039 Control: capture_start with capture_len=0 -> capture_busy stays 0; capture_start during CAPTURE -> ignored, word count unchanged.
REQ-040 Reset: adc_rst pulsed after 2 of 5 words written -> m_valid=0 and capture_busy=0 immediately; a new capture_len=1 capture then completes normally.

Source files
------------

// File: rtl/ad9467_adc_capture.sv
// Packs pairs of 16-bit ADC samples into 32-bit words for a length-bounded capture,
// buffering them in a first-word-fall-through FIFO with sticky overflow reporting.
module ad9467_adc_capture #(
    parameter int FIFO_AW = 4
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic        adc_valid,
    input  logic        adc_enable,
    input  logic [15:0] adc_data,
    output logic        adc_dovf,
    input  logic        ovf_clear,
    input  logic        capture_start,
    input  logic [15:0] capture_len,
    output logic        capture_busy,
    output logic        capture_done,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [1:0]  dbg_state
);

    // m_valid/m_ready: a word transfers on every edge where both are high;
    // while m_valid=1 and m_ready=0 the presented word and m_last hold steady.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    state_t             state_q, state_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic               phase_q, phase_d;
    logic [15:0]        low_q, low_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               dovf_q, dovf_d;
    logic               done_q, done_d;
    logic [32:0]        mem_q [DEPTH];

    logic               fifo_empty, fifo_full, fifo_one;
    logic [FIFO_AW:0]   fill;
    logic               start_ok, pop, accept, wr_req, wr_en, ovf, wr_last;
    logic [32:0]        rd_word;

    always_comb begin
        fill       = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        fifo_one   = (fill == PTR_ONE);
        start_ok   = capture_start && (capture_len != 16'd0);
        pop        = !fifo_empty && m_ready;
        accept     = (state_q == ST_CAPTURE) && adc_valid && adc_enable;
        wr_req     = accept && phase_q;
        // A full FIFO still takes the word when a pop frees a slot on the same edge.
        wr_en      = wr_req && (!fifo_full || pop);
        ovf        = wr_req && fifo_full && !pop;
        wr_last    = (cnt_q == 16'd1);
        rd_word    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= 1'b0;
            low_q    <= 16'd0;
            cnt_q    <= 16'd0;
            dovf_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            phase_q  <= phase_d;
            low_q    <= low_d;
            cnt_q    <= cnt_d;
            dovf_q   <= dovf_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {wr_last, adc_data, low_q};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_ok) state_d = ST_CAPTURE;
            ST_CAPTURE: if (ovf || (wr_en && wr_last)) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty || (fifo_one && pop)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        phase_d  = phase_q;
        low_d    = low_q;
        cnt_d    = cnt_q;
        if ((state_q == ST_IDLE) && start_ok) begin
            cnt_d   = capture_len;
            phase_d = 1'b0;
        end
        if (accept && !phase_q) begin
            low_d   = adc_data;
            phase_d = 1'b1;
        end
        if (wr_en) begin
            phase_d = 1'b0;
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        end
        // An overflow aborts the capture and drops the half-built word.
        if (ovf) phase_d = 1'b0;
        dovf_d = ovf ? 1'b1 : (ovf_clear ? 1'b0 : dovf_q);
        done_d = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
    end

    always_comb begin
        capture_busy = (state_q != ST_IDLE);
        capture_done = done_q;
        adc_dovf     = dovf_q;
        m_valid      = !fifo_empty;
        m_data       = m_valid ? rd_word[31:0] : 32'd0;
        m_last       = m_valid ? rd_word[32] : 1'b0;
        dbg_state    = state_q;
    end

endmodule
